// File: rtl/ps2_teclado_rx_if.sv
// Controller-side bundle of the PS/2 keyboard receiver: decoded key code,
// level interrupt with its acknowledge, and per-frame status pulses.
interface ps2_teclado_rx_if;
  logic [7:0] tecla;
  logic       interrupt;
  logic       interrupt_ack;
  logic       rx_done_tick;
  logic       frame_err;

  // Receiver side
  modport master (
    output tecla,
    output interrupt,
    output rx_done_tick,
    output frame_err,
    input  interrupt_ack
  );

  // Controller side
  modport slave (
    input  tecla,
    input  interrupt,
    input  rx_done_tick,
    input  frame_err,
    output interrupt_ack
  );
endinterface

// File: rtl/ps2_teclado_rx.sv
// PS/2 keyboard receiver and command-key decoder for the PicoBlaze controller.
// Deserialises device-to-host frames, translates make codes of the command keys,
// holds the key code while pressed and raises a level interrupt per new press.
// Optional feature: define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_teclado_rx #(
  parameter int unsigned FILTRO      = 8,
  parameter int unsigned TIMEOUT_CYC = 10000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ps2c,
  input  logic               ps2d,
  ps2_teclado_rx_if.master   bus
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StDps, StLoad} state_e;

  // Input conditioning
  logic              c_meta_q, c_sync_q, d_meta_q, d_sync_q;
  logic [FILTRO-1:0] filt_q, filt_d;
  logic              f_clk_q, f_clk_d;
  logic              fall;

  // Receive path
  state_e          state_q, state_d;
  logic [3:0]      n_q, n_d;
  logic [9:0]      b_q, b_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            to_hit;
  logic            frame_ok;
  logic            rx_done;
  logic [7:0]      data;

  // Key decoding
  logic [7:0] tecla_q, tecla_d;
  logic [7:0] held_q, held_d;
  logic       brk_q, brk_d;
  logic       ext_q, ext_d;
  logic       irq_q, irq_d;
  logic       irq_set;
  logic       mapped;
  logic [7:0] code;

  // Two-stage synchronisers; idle PS/2 lines are high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_meta_q <= 1'b1;
      c_sync_q <= 1'b1;
      d_meta_q <= 1'b1;
      d_sync_q <= 1'b1;
    end else begin
      c_meta_q <= ps2c;
      c_sync_q <= c_meta_q;
      d_meta_q <= ps2d;
      d_sync_q <= d_meta_q;
    end
  end

  // Glitch filter: the clock only changes after FILTRO equal samples
  always_comb begin
    filt_d  = {filt_q[FILTRO-2:0], c_sync_q};
    f_clk_d = f_clk_q;
    if (&filt_q) begin
      f_clk_d = 1'b1;
    end else if (filt_q == '0) begin
      f_clk_d = 1'b0;
    end
  end

  // Filter state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q  <= '1;
      f_clk_q <= 1'b1;
    end else begin
      filt_q  <= filt_d;
      f_clk_q <= f_clk_d;
    end
  end

  assign fall = f_clk_q & ~f_clk_d;

  // Receive FSM next state, shift register and mid-frame timeout
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    b_d     = b_q;
    to_d    = to_q;
    to_hit  = 1'b0;
    if (fall) begin
      to_d = '0;
    end else if (state_q == StDps) begin
      to_d = to_q + 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        to_d = '0;
        if (fall && !d_sync_q) begin
          n_d     = 4'd0;
          state_d = StDps;
        end
      end
      StDps: begin
        if (fall) begin
          b_d = {d_sync_q, b_q[9:1]};
          if (n_q == 4'd9) begin
            state_d = StLoad;
          end else begin
            n_d = n_q + 4'd1;
          end
        end else if (to_q == TO_LAST) begin
          to_hit  = 1'b1;
          state_d = StIdle;
        end
      end
      StLoad: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Receive FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      n_q     <= 4'd0;
      b_q     <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      b_q     <= b_d;
      to_q    <= to_d;
    end
  end

  // b_q = {stop, parity, data[7:0]}
`ifdef PS2_PARITY_CHECK_EN
  assign frame_ok = b_q[9] & (^b_q[8:0]);
`else
  logic unused_parity;
  assign unused_parity = b_q[8];
  assign frame_ok = b_q[9];
`endif

  assign data    = b_q[7:0];
  assign rx_done = (state_q == StLoad) && frame_ok;

  // Frame status pulses
  always_comb begin
    bus.rx_done_tick = rx_done;
    bus.frame_err    = ((state_q == StLoad) && !frame_ok) || to_hit;
  end

  // Scan code to controller command code
  always_comb begin
    mapped = 1'b1;
    code   = 8'h00;
    unique case (data)
      8'h1D:   code = 8'h57;
      8'h1B:   code = 8'h53;
      8'h1C:   code = 8'h41;
      8'h23:   code = 8'h44;
      8'h43:   code = 8'h49;
      8'h4D:   code = 8'h50;
      8'h2D:   code = 8'h08;
      default: mapped = 1'b0;
    endcase
  end

  // Prefix tracking, held-key update and interrupt request
  always_comb begin
    tecla_d = tecla_q;
    held_d  = held_q;
    brk_d   = brk_q;
    ext_d   = ext_q;
    irq_set = 1'b0;
    if (rx_done) begin
      if (data == 8'hF0) begin
        brk_d = 1'b1;
      end else if (data == 8'hE0) begin
        ext_d = 1'b1;
      end else if (ext_q) begin
        // Extended keys are not commands; drop the whole sequence
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else if (brk_q) begin
        brk_d = 1'b0;
        if (data == held_q) begin
          tecla_d = 8'h00;
          // Forget the key so the next press of it interrupts again
          held_d  = 8'h00;
        end
      end else if (mapped && (data != held_q)) begin
        tecla_d = code;
        held_d  = data;
        irq_set = 1'b1;
      end
    end
    // A new key wins over a simultaneous acknowledge
    if (irq_set) begin
      irq_d = 1'b1;
    end else if (bus.interrupt_ack) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  // Decoder state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tecla_q <= 8'h00;
      held_q  <= 8'h00;
      brk_q   <= 1'b0;
      ext_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      tecla_q <= tecla_d;
      held_q  <= held_d;
      brk_q   <= brk_d;
      ext_q   <= ext_d;
      irq_q   <= irq_d;
    end
  end

  // Controller-facing key code and interrupt
  always_comb begin
    bus.tecla     = tecla_q;
    bus.interrupt = irq_q;
  end

endmodule

// File: tb/tb_ps2_teclado_rx.sv
// Directed bench for ps2_teclado_rx: make/break/repeat handling, prefix filtering,
// frame errors, timeout, interrupt overlap and asynchronous reset mid-frame.
module tb_ps2_teclado_rx;

  localparam int unsigned TO_CYC = 2000;

  logic clk;
  logic reset;
  logic ps2c;
  logic ps2d;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_ferr   = 0;
  int n_rise   = 0;
  logic irq_prev = 1'b0;

  int b_done, b_ferr, b_rise;
  logic saw_done;

  ps2_teclado_rx_if bus ();

  ps2_teclado_rx #(
    .FILTRO      (8),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ps2c  (ps2c),
    .ps2d  (ps2d),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters, sampled away from the active edge
  always @(negedge clk) begin
    if (bus.rx_done_tick === 1'b1) n_done++;
    if (bus.frame_err === 1'b1) n_ferr++;
    if (bus.interrupt === 1'b1 && irq_prev !== 1'b1) n_rise++;
    irq_prev = bus.interrupt;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sends the first nbits of {stop, parity, data, start} LSB first
  task automatic send_bits(input logic [7:0] data, input logic par, input logic stop,
                           input int nbits);
    logic [10:0] fr;
    fr = {stop, par, data, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2d = fr[i];
      repeat (10) @(posedge clk);
      ps2c = 1'b0;
      repeat (20) @(posedge clk);
      ps2c = 1'b1;
      repeat (10) @(posedge clk);
    end
    ps2d = 1'b1;
  endtask

  task automatic send_key(input logic [7:0] data);
    send_bits(data, ~^data, 1'b1, 11);
    repeat (30) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic snap();
    b_done = n_done;
    b_ferr = n_ferr;
    b_rise = n_rise;
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    bus.interrupt_ack = 1'b1;
    @(negedge clk);
    bus.interrupt_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    ps2c  = 1'b1;
    ps2d  = 1'b1;
    bus.interrupt_ack = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset_tecla", 32'(bus.tecla), 32'h00);
    check("reset_irq", 32'(bus.interrupt), 32'h0);
    check("reset_done", 32'(bus.rx_done_tick), 32'h0);
    check("reset_ferr", 32'(bus.frame_err), 32'h0);
    reset = 1'b0;
    repeat (20) @(posedge clk);

    // Make W, then acknowledge
    snap();
    send_key(8'h1D);
    check("w_done", 32'(n_done - b_done), 32'd1);
    check("w_tecla", 32'(bus.tecla), 32'h57);
    check("w_irq", 32'(bus.interrupt), 32'h1);
    pulse_ack();
    check("w_ack_irq", 32'(bus.interrupt), 32'h0);
    check("w_ack_tecla", 32'(bus.tecla), 32'h57);

    // Hold P with typematic repeats, then release
    snap();
    for (int i = 0; i < 3; i++) begin
      send_key(8'h4D);
      check("p_hold_tecla", 32'(bus.tecla), 32'h50);
    end
    send_key(8'hF0);
    check("p_brk_tecla", 32'(bus.tecla), 32'h50);
    send_key(8'h4D);
    check("p_rel_tecla", 32'(bus.tecla), 32'h00);
    check("p_irq_count", 32'(n_rise - b_rise), 32'd1);
    check("p_done", 32'(n_done - b_done), 32'd5);
    pulse_ack();

    // Extended prefix and unmapped code are ignored
    snap();
    send_key(8'hE0);
    send_key(8'h1C);
    send_key(8'h77);
    check("filt_tecla", 32'(bus.tecla), 32'h00);
    check("filt_irq", 32'(n_rise - b_rise), 32'd0);
    check("filt_done", 32'(n_done - b_done), 32'd3);

    // Stop bit 0
    snap();
    send_bits(8'h1D, ~^8'h1D, 1'b0, 11);
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("stop_ferr", 32'(n_ferr - b_ferr), 32'd1);
    check("stop_done", 32'(n_done - b_done), 32'd0);
    check("stop_tecla", 32'(bus.tecla), 32'h00);

    // Wrong parity on S
    snap();
    send_bits(8'h1B, ^8'h1B, 1'b1, 11);
    repeat (30) @(posedge clk);
    @(negedge clk);
`ifdef PS2_PARITY_CHECK_EN
    check("par_ferr", 32'(n_ferr - b_ferr), 32'd1);
    check("par_tecla", 32'(bus.tecla), 32'h00);
`else
    check("par_ferr", 32'(n_ferr - b_ferr), 32'd0);
    check("par_tecla", 32'(bus.tecla), 32'h53);
    check("par_irq", 32'(bus.interrupt), 32'h1);
    pulse_ack();
`endif

    // Stall after 5 bits
    snap();
    send_bits(8'h00, 1'b1, 1'b1, 5);
    repeat (1500) @(negedge clk);
    check("to_early", 32'(n_ferr - b_ferr), 32'd0);
    repeat (1000) @(negedge clk);
    check("to_ferr", 32'(n_ferr - b_ferr), 32'd1);

    // A then D without ack
    send_key(8'h1C);
    check("ov_a_tecla", 32'(bus.tecla), 32'h41);
    check("ov_a_irq", 32'(bus.interrupt), 32'h1);
    send_key(8'h23);
    check("ov_d_tecla", 32'(bus.tecla), 32'h44);
    check("ov_d_irq", 32'(bus.interrupt), 32'h1);
    pulse_ack();
    check("ov_ack_irq", 32'(bus.interrupt), 32'h0);

    // Ack in the same cycle as a new key
    saw_done = 1'b0;
    fork
      send_key(8'h1D);
      begin
        for (int i = 0; i < 1000; i++) begin
          @(negedge clk);
          if (bus.rx_done_tick === 1'b1) begin
            bus.interrupt_ack = 1'b1;
            @(negedge clk);
            bus.interrupt_ack = 1'b0;
            saw_done = 1'b1;
            break;
          end
        end
      end
    join
    check("same_seen", 32'(saw_done), 32'h1);
    check("same_irq", 32'(bus.interrupt), 32'h1);
    check("same_tecla", 32'(bus.tecla), 32'h57);

    // Asynchronous reset with 4 bits of a frame sent
    snap();
    send_bits(8'h2D, ~^8'h2D, 1'b1, 4);
    #3;
    reset = 1'b1;
    #1;
    check("rst_tecla", 32'(bus.tecla), 32'h00);
    check("rst_irq", 32'(bus.interrupt), 32'h0);
    repeat (5) @(posedge clk);
    reset = 1'b0;
    repeat (30) @(posedge clk);
    send_key(8'h1D);
    check("rst_done", 32'(n_done - b_done), 32'd1);
    check("rst_ferr", 32'(n_ferr - b_ferr), 32'd0);
    check("rst_w_tecla", 32'(bus.tecla), 32'h57);
    check("rst_w_irq", 32'(bus.interrupt), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_teclado_rx.md
# ps2_teclado_rx

PS/2 keyboard receiver and key decoder that feeds the PicoBlaze controller's `in_port` and `interrupt` inputs. It deserialises PS/2 device-to-host frames and translates the command keys' make codes to the ASCII-style codes the controller firmware and output decoders expect. It holds the current key code on the port while the key is pressed, and raises a level interrupt per new key press until the controller acknowledges it.

## Interface
- `FILTRO`, 8: length of the `ps2c` glitch filter, in consecutive equal samples.
- `TIMEOUT_CYC`, 10000: `clk` cycles without a filtered `ps2c` falling edge mid-frame before the frame is aborted.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `ps2c` in 1: PS/2 clock from the keyboard, asynchronous.
- `ps2d` in 1: PS/2 data from the keyboard, asynchronous.
- `interrupt_ack` in 1: acknowledge pulse from the controller.
- `tecla` out 8: decoded key code, connected to `in_port`.
- `interrupt` out 1: new-key interrupt request.
- `rx_done_tick` out 1: one-cycle pulse per accepted frame.
- `frame_err` out 1: one-cycle pulse per rejected frame.

## Operation
- Input conditioning:
  - `ps2c` and `ps2d` each pass through a 2-FF synchroniser.
  - Synchronised `ps2c` feeds a `FILTRO`-bit shift filter. The filtered clock goes to 1 on all-ones and to 0 on all-zeros; otherwise it holds.
  - A falling edge of the filtered clock is the sample strobe (`fall`).
- Receive FSM states: `IDLE`, `DPS`, `LOAD`.
  - `IDLE`: on `fall` with `ps2d`=0 (start bit), clear the bit counter and go to `DPS`. On `fall` with `ps2d`=1, stay in `IDLE`.
  - `DPS`: each `fall` shifts `ps2d` into a 10-bit register, LSB first (8 data bits, odd parity, stop bit). After the 10th sample go to `LOAD`.
  - `LOAD`: one cycle. Validate the frame, pulse `rx_done_tick` or `frame_err`, then return to `IDLE`.
- Frame validity: stop bit must be 1. Parity is checked only per Configuration. An invalid frame pulses `frame_err` and is discarded.
- Timeout: a counter clears on every `fall`. If it reaches `TIMEOUT_CYC` in `DPS`, return to `IDLE` and pulse `frame_err`.
- Code handling (valid frames only):
  - `0xF0`: set `brk`.
  - `0xE0`: set `ext`.
  - Any other byte with `ext`=1: discard, then clear `ext` and `brk`.
  - Any other byte with `brk`=1 (break code): if it matches the held key, `tecla`←0x00. Clear `brk`. No interrupt.
  - Any other byte with `brk`=0 and `ext`=0 (make code): translate it.
    - Unmapped byte: discarded.
    - Mapped byte equal to the held key (typematic repeat): ignored.
    - Otherwise: `tecla`←translated code, held-key←scan code, `interrupt`←1.
- Translation table: 0x1D→0x57 (W), 0x1B→0x53 (S), 0x1C→0x41 (A), 0x23→0x44 (D), 0x43→0x49 (I), 0x4D→0x50 (P), 0x2D→0x08 (R, reset command).
- Interrupt:
  - Set by a new make code; cleared by `interrupt_ack`=1.
  - Set and ack in the same cycle: set wins.
  - A second make while `interrupt`=1 updates `tecla`; `interrupt` stays 1 (no queue).
- Reset values:
  - `tecla`=0x00; `interrupt`, `rx_done_tick`, `frame_err`=0.
  - FSM=`IDLE`; `brk`=`ext`=0; held-key=0x00.
  - Filter register and filtered clock all ones.
- Reset mid-frame aborts the frame; nothing is emitted.

## Timing
- `fall` occurs 2 synchroniser cycles plus `FILTRO` cycles after the physical `ps2c` edge (10 cycles at default).
- `rx_done_tick` and `frame_err` assert in the `LOAD` cycle, one cycle after the 10th `fall`.
- `tecla` and `interrupt` update on the clock after `rx_done_tick`.
- `interrupt` falls on the clock after the `interrupt_ack` sample.
- `tecla` is stable between updates. It is never 0x00-glitched except by a release of the held key.

## Configuration
- `PS2_PARITY_CHECK_EN`:
  - Defined: the frame is rejected unless its data bits plus parity bit contain an odd number of ones. A rejected frame pulses `frame_err`.
  - Undefined: the parity bit is captured and ignored; only the stop bit is checked.

## Test plan
- Reset: assert `reset` asynchronously mid-frame with 4 bits sent -> `tecla`=0x00, `interrupt`=0; the next full frame 0x1D decodes normally.
- Make W: send 0x1D -> one `rx_done_tick`, then `tecla`=0x57 and `interrupt`=1; pulse `interrupt_ack` -> `interrupt`=0 and `tecla` stays 0x57.
- Hold/release P: send 0x4D, 0x4D, 0x4D, then 0xF0, 0x4D -> `tecla`=0x50 throughout with exactly one interrupt; after the release `tecla`=0x00.
- Filtering: send 0xE0 0x1C, then 0x77 -> no `tecla` change, no interrupt, 3 `rx_done_tick`.
- Errors:
  - Stop bit=0 -> `frame_err` pulse, `tecla` unchanged.
  - Wrong parity with the macro defined -> `frame_err`; without it -> accepted.
  - Stall after 5 bits -> `frame_err` after `TIMEOUT_CYC` cycles.
- Overlap: send A (0x1C) then D (0x23) without ack -> `tecla`=0x44 and `interrupt` stays 1. Set and ack in the same cycle -> `interrupt` stays 1.
